// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
package uart_pkg;

    localparam int unsigned DATA_MAX = 8;
    localparam int unsigned SHIFT_W  = DATA_MAX + 1;

    localparam logic [1:0] WLS_5 = 2'b00;
    localparam logic [1:0] WLS_6 = 2'b01;
    localparam logic [1:0] WLS_7 = 2'b10;
    localparam logic [1:0] WLS_8 = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        START,
        BITS
    } rx_state_e;

    function automatic logic [3:0] data_bits(input logic [1:0] wls);
        return 4'd5 + {2'b00, wls};
    endfunction

endpackage

// File: rtl/rx_parity_check.sv
// Combinational parity checker for one received character (normal or stick parity).
module rx_parity_check (
    input  logic [7:0] data_i,
    input  logic       pbit_i,
    input  logic [1:0] wls_i,
    input  logic       eps_i,
    input  logic       sp_i,
    output logic       parity_err_o
);
    import uart_pkg::*;

    logic data_xor;

    always_comb begin
        data_xor = 1'b0;
        unique case (wls_i)
            WLS_5: data_xor = ^data_i[4:0];
            WLS_6: data_xor = ^data_i[5:0];
            WLS_7: data_xor = ^data_i[6:0];
            WLS_8: data_xor = ^data_i[7:0];
            default: data_xor = 1'b0;
        endcase
    end

    // Stick parity ignores the data; the bit must simply equal ~eps.
    assign parity_err_o = sp_i ? (pbit_i != ~eps_i) : ((data_xor ^ pbit_i) != ~eps_i);

endmodule

// File: rtl/receive_controller.sv
// UART receive sequencer: start detect, LSB-first shift-in, and per-frame
// parity/framing/break checking with a registered one-cycle rx_valid.
module receive_controller #(
    parameter int unsigned DATA_MAX = uart_pkg::DATA_MAX,
    parameter int unsigned SHIFT_W  = uart_pkg::SHIFT_W
) (
    input  logic                pclk,
    input  logic                presetn,
    input  logic                rxd,
    input  logic                sample_edge,
    input  logic                receive_done,
    input  logic [1:0]          wls,
    input  logic                pen,
    input  logic                eps,
    input  logic                sp,
    output logic                sample_restart,
    output logic                receive_frame_counter_en,
    output logic                receive_frame_counter_clear,
    output logic [DATA_MAX-1:0] rx_data,
    output logic                rx_valid,
    output logic                parity_err,
    output logic                framing_err,
    output logic                break_int
);
    import uart_pkg::*;

    localparam logic [3:0] ShiftW4 = 4'(SHIFT_W);

    rx_state_e           state_q;
    logic [SHIFT_W-1:0]  shreg_q;
    logic                rxd_q;
    logic                restart_q;
    logic                clear_q;
    logic [DATA_MAX-1:0] rx_data_q;
    logic                rx_valid_q;
    logic                parity_err_q;
    logic                framing_err_q;
    logic                break_q;

    logic [3:0]          dbits;
    logic [3:0]          width;
    logic [3:0]          shamt;
    logic [SHIFT_W-1:0]  aligned;
    logic [DATA_MAX-1:0] mask;
    logic [DATA_MAX-1:0] data_w;
    logic                pbit;
    logic                perr_raw;
    logic                perr_w;
    logic                break_w;

    // Frame bits sit in the top W positions of the shift register after W shifts.
    assign dbits   = data_bits(wls);
    assign width   = dbits + {3'b000, pen};
    assign shamt   = ShiftW4 - width;
    assign aligned = shreg_q >> shamt;
    assign mask    = ~({DATA_MAX{1'b1}} << dbits);
    assign data_w  = aligned[DATA_MAX-1:0] & mask;
    assign pbit    = pen & shreg_q[SHIFT_W-1];

    rx_parity_check u_parity (
        .data_i       (data_w),
        .pbit_i       (pbit),
        .wls_i        (wls),
        .eps_i        (eps),
        .sp_i         (sp),
        .parity_err_o (perr_raw)
    );

    assign perr_w  = pen & perr_raw;
    assign break_w = (data_w == '0) & (~pen | ~pbit) & ~rxd;

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state_q       <= IDLE;
            shreg_q       <= '0;
            rxd_q         <= 1'b1;
            restart_q     <= 1'b0;
            clear_q       <= 1'b0;
            rx_data_q     <= '0;
            rx_valid_q    <= 1'b0;
            parity_err_q  <= 1'b0;
            framing_err_q <= 1'b0;
            break_q       <= 1'b0;
        end else begin
            rxd_q      <= rxd;
            restart_q  <= 1'b0;
            rx_valid_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    clear_q <= 1'b1;
                    // Falling edge only, so a line stuck low cannot retrigger.
                    if (rxd_q && !rxd) begin
                        state_q   <= START;
                        restart_q <= 1'b1;
                    end
                end
                START: begin
                    clear_q <= 1'b1;
                    if (sample_edge) begin
                        if (rxd) begin
                            state_q <= IDLE;
                        end else begin
                            state_q <= BITS;
                            clear_q <= 1'b0;
                        end
                    end
                end
                BITS: begin
                    clear_q <= 1'b0;
                    if (receive_done) begin
                        state_q       <= IDLE;
                        clear_q       <= 1'b1;
                        rx_data_q     <= data_w;
                        parity_err_q  <= perr_w;
                        framing_err_q <= ~rxd;
                        break_q       <= break_w;
                        rx_valid_q    <= 1'b1;
                    end else if (sample_edge) begin
                        shreg_q <= {rxd, shreg_q[SHIFT_W-1:1]};
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign sample_restart              = restart_q;
    assign receive_frame_counter_en    = (state_q == BITS) & sample_edge & ~receive_done;
    assign receive_frame_counter_clear = clear_q;
    assign rx_data                     = rx_data_q;
    assign rx_valid                    = rx_valid_q;
    assign parity_err                  = parity_err_q;
    assign framing_err                 = framing_err_q;
    assign break_int                   = break_q;

endmodule
